// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle for if_id_buffer; o_dbg_issued exists only with IF_ID_DEBUG_EN.
`default_nettype none

interface if_id_buffer_if #(
   parameter int NBITS = 32
);
   logic             i_enable;
   logic             i_valid;
   logic [NBITS-1:0] i_instruction;
   logic [NBITS-1:0] i_pc_plus1;
   logic             i_halt_signal;
   logic             i_stall;
   logic             i_flush;
   logic [NBITS-1:0] o_instruction;
   logic [NBITS-1:0] o_pc_plus1;
   logic             o_valid;
   logic             o_fetch_stall;
   logic             o_halt;
   logic             o_overflow;
`ifdef IF_ID_DEBUG_EN
   logic [31:0]      o_dbg_issued;
`endif

   modport master (
      output i_enable, i_valid, i_instruction, i_pc_plus1, i_halt_signal, i_stall, i_flush,
`ifdef IF_ID_DEBUG_EN
      input  o_dbg_issued,
`endif
      input  o_instruction, o_pc_plus1, o_valid, o_fetch_stall, o_halt, o_overflow
   );

   modport slave (
      input  i_enable, i_valid, i_instruction, i_pc_plus1, i_halt_signal, i_stall, i_flush,
`ifdef IF_ID_DEBUG_EN
      output o_dbg_issued,
`endif
      output o_instruction, o_pc_plus1, o_valid, o_fetch_stall, o_halt, o_overflow
   );
endinterface

`default_nettype wire

// File: rtl/if_id_buffer.sv
// Two-entry elastic IF/ID skid buffer with flush and HALT drain.
// IF_ID_DEBUG_EN adds a 32-bit issued-instruction counter (o_dbg_issued).
`default_nettype none

module if_id_buffer #(
   parameter int NBITS = 32
) (
   input  wire logic      i_clk,
   input  wire logic      i_reset,
   if_id_buffer_if.slave  bus
);
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t           state;
   logic [NBITS-1:0] instr_mem [2];
   logic [NBITS-1:0] pc_mem    [2];
   logic [1:0]       halt_mem;
   logic             head;
   logic             tail;
   logic [1:0]       count;
   logic             overflow;

   logic             head_valid;
   logic             attempt;
   logic             flush_eff;
   logic             pop;
   logic             push;

   assign head_valid = (count != 2'd0) && (state != HALTED);
   // Flush in HALTED is ignored; elsewhere it cancels any same-cycle push/pop.
   assign flush_eff  = bus.i_enable && bus.i_flush && (state != HALTED);
   assign pop        = bus.i_enable && head_valid && !bus.i_stall && !flush_eff;
   assign attempt    = bus.i_enable && bus.i_valid && !bus.i_flush && (state == RUN);
   assign push       = attempt && ((count != 2'd2) || pop);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state    <= RUN;
         head     <= 1'b0;
         tail     <= 1'b0;
         count    <= 2'd0;
         overflow <= 1'b0;
         halt_mem <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            instr_mem[i] <= '0;
            pc_mem[i]    <= '0;
         end
      end else if (flush_eff) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
         if (state == DRAIN)
            state <= RUN;
      end else begin
         if (push) begin
            instr_mem[tail] <= bus.i_instruction;
            pc_mem[tail]    <= bus.i_pc_plus1;
            halt_mem[tail]  <= bus.i_halt_signal;
            tail            <= ~tail;
         end
         if (pop)
            head <= ~head;
         if (push && !pop)
            count <= count + 2'd1;
         else if (pop && !push)
            count <= count - 2'd1;
         if (attempt && (count == 2'd2) && !pop)
            overflow <= 1'b1;
         case (state)
            RUN:     if (push && bus.i_halt_signal) state <= DRAIN;
            DRAIN:   if (pop && halt_mem[head])     state <= HALTED;
            default: state <= state;
         endcase
      end
   end

   assign bus.o_valid       = head_valid;
   assign bus.o_instruction = head_valid ? instr_mem[head] : '0;
   assign bus.o_pc_plus1    = head_valid ? pc_mem[head]    : '0;
   assign bus.o_fetch_stall = (count == 2'd2) || ((count == 2'd1) && bus.i_stall) || (state != RUN);
   assign bus.o_halt        = (state == HALTED);
   assign bus.o_overflow    = overflow;

`ifdef IF_ID_DEBUG_EN
   logic [31:0] dbg_issued;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)
         dbg_issued <= 32'd0;
      else if (pop)
         dbg_issued <= dbg_issued + 32'd1;
   end

   assign bus.o_dbg_issued = dbg_issued;
`endif

endmodule

`default_nettype wire
